// File: rtl/pc_bus_pkg.sv
// Shared definitions for the PC bus controller: FSM encoding, command strobe
// indices and the default wait-state / timeout settings.
package pc_bus_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      CMD  = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } bus_state_e;

   // Internal strobe vector is active-high; bit positions below.
   localparam int STB_MEMR = 0;
   localparam int STB_MEMW = 1;
   localparam int STB_IOR  = 2;
   localparam int STB_IOW  = 3;
   localparam int NUM_STB  = 4;

   localparam int DEF_MEM_WS = 0;
   localparam int DEF_IO_WS  = 1;
   localparam int DEF_TMO    = 255;

   localparam int WS_W  = 4;
   localparam int CNT_W = 8;

   function automatic logic [NUM_STB-1:0] strobe_sel(input logic io, input logic wr);
      logic [NUM_STB-1:0] s;
      s = '0;
      case ({io, wr})
         2'b00:   s[STB_MEMR] = 1'b1;
         2'b01:   s[STB_MEMW] = 1'b1;
         2'b10:   s[STB_IOR]  = 1'b1;
         default: s[STB_IOW]  = 1'b1;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Shared wait-state / timeout counter: counts wait states down in CMD, then
// counts sys_rdy-low clocks up in WAIT starting from the zero it reached.
module bus_wait_timer
   import pc_bus_pkg::*;
#(
   parameter int TMO = DEF_TMO
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [WS_W-1:0] load_val,
   input  logic            dec,
   input  logic            inc,
   output logic            zero,
   output logic            expired
);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples its inputs from before the clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= {{(CNT_W-WS_W){1'b0}}, load_val};
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign zero    = (cnt == '0);
   // High on the WAIT clock whose increment would bring the count to TMO.
   assign expired = (cnt == CNT_W'(TMO - 1));

endmodule

// File: rtl/pc_bus_ctrl.sv
// PC bus controller: turns a multiplexed CPU bus cycle into one active-low
// system command strobe, with wait states, sys_rdy timeout and abort handling.
module pc_bus_ctrl
   import pc_bus_pkg::*;
#(
   parameter int MEM_WS = DEF_MEM_WS,
   parameter int IO_WS  = DEF_IO_WS,
   parameter int TMO    = DEF_TMO
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] a,
   input  logic [7:0]  ad_i,
   input  logic        ale,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        iom,
   input  logic        den_n,
   input  logic        dtr,
   output logic [7:0]  ad_o,
   output logic        ad_oe,
   output logic        ready,
   output logic [19:0] sys_addr,
   output logic [7:0]  sys_dat_o,
   input  logic [7:0]  sys_dat_i,
   output logic        memr_n,
   output logic        memw_n,
   output logic        ior_n,
   output logic        iow_n,
   input  logic        sys_rdy,
   output logic        bus_err
);

   bus_state_e         state_q, state_d;
   logic               io_cyc, rd_cyc;
   logic [NUM_STB-1:0] stb_q;
   logic [7:0]         rd_data;

   logic               latch_addr, start_cmd, end_cmd, cap_rd, proto_err, tmo_err;
   logic               tmr_load, tmr_dec, tmr_inc, tmr_zero, tmr_expired;
   logic               cpu_released;
   logic [WS_W-1:0]    ws_val;

   // The CPU ends or aborts the transfer by raising the strobe it asserted.
   assign cpu_released = rd_cyc ? rd_n : wr_n;
   assign ws_val       = io_cyc ? WS_W'(IO_WS) : WS_W'(MEM_WS);

   bus_wait_timer #(.TMO(TMO)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (ws_val),
      .dec      (tmr_dec),
      .inc      (tmr_inc),
      .zero     (tmr_zero),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      latch_addr = 1'b0;
      start_cmd  = 1'b0;
      end_cmd    = 1'b0;
      cap_rd     = 1'b0;
      proto_err  = 1'b0;
      tmo_err    = 1'b0;
      tmr_load   = 1'b0;
      tmr_dec    = 1'b0;
      tmr_inc    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ale) begin
               latch_addr = 1'b1;
               state_d    = ADDR;
            end
         end
         ADDR: begin
            if (!rd_n && !wr_n) begin
               proto_err = 1'b1;
               state_d   = IDLE;
            end else if (!rd_n || !wr_n) begin
               start_cmd = 1'b1;
               tmr_load  = 1'b1;
               state_d   = CMD;
            end
         end
         CMD: begin
            if (cpu_released) begin
               end_cmd = 1'b1;
               state_d = IDLE;
            end else if (!tmr_zero) begin
               tmr_dec = 1'b1;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cpu_released) begin
               end_cmd = 1'b1;
               state_d = IDLE;
            end else if (sys_rdy) begin
               cap_rd  = 1'b1;
               state_d = DONE;
            end else if (tmr_expired) begin
               tmo_err = 1'b1;
               state_d = DONE;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         DONE: begin
            if (rd_n && wr_n) begin
               end_cmd = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         io_cyc    <= 1'b0;
         rd_cyc    <= 1'b0;
         stb_q     <= '0;
         sys_addr  <= '0;
         sys_dat_o <= '0;
         rd_data   <= '0;
         bus_err   <= 1'b0;
      end else begin
         bus_err <= proto_err | tmo_err;
         if (latch_addr) begin
            sys_addr <= a;
            io_cyc   <= iom;
         end
         // ADDR only starts a command when exactly one of rd_n/wr_n is low.
         if (start_cmd) begin
            rd_cyc <= !rd_n;
            stb_q  <= strobe_sel(io_cyc, !wr_n);
            if (!wr_n) sys_dat_o <= ad_i;
         end
         if (end_cmd) stb_q <= '0;
         if (cap_rd && rd_cyc) rd_data <= sys_dat_i;
         if (tmo_err) rd_data <= 8'hFF;
      end
   end

   assign memr_n = !stb_q[STB_MEMR];
   assign memw_n = !stb_q[STB_MEMW];
   assign ior_n  = !stb_q[STB_IOR];
   assign iow_n  = !stb_q[STB_IOW];

   assign ready  = (state_q == IDLE) || (state_q == DONE);
   assign ad_o   = rd_data;
   assign ad_oe  = (state_q == DONE) && rd_cyc && !den_n && !dtr;

endmodule

// File: tb/tb_pc_bus_ctrl.sv
// Scoreboard bench for pc_bus_ctrl: directed CPU cycles push expected
// transactions; a negedge monitor assembles observed transactions and compares.
module tb_pc_bus_ctrl;

   logic        clk;
   logic        rst;
   logic [19:0] a;
   logic [7:0]  ad_i;
   logic        ale, rd_n, wr_n, iom, den_n, dtr;
   logic [7:0]  sys_dat_i;
   logic        sys_rdy;

   logic [7:0]  u0_ad_o, u1_ad_o;
   logic        u0_ad_oe, u1_ad_oe, u0_ready, u1_ready, u0_bus_err, u1_bus_err;
   logic [19:0] u0_sys_addr, u1_sys_addr;
   logic [7:0]  u0_sys_dat_o, u1_sys_dat_o;
   logic        u0_memr_n, u0_memw_n, u0_ior_n, u0_iow_n;
   logic        u1_memr_n, u1_memw_n, u1_ior_n, u1_iow_n;

   // Instance u0: zero-wait memory, one-wait I/O, short timeout.
   pc_bus_ctrl #(.MEM_WS(0), .IO_WS(1), .TMO(4)) u0 (
      .clk(clk), .rst(rst), .a(a), .ad_i(ad_i), .ale(ale), .rd_n(rd_n), .wr_n(wr_n),
      .iom(iom), .den_n(den_n), .dtr(dtr), .ad_o(u0_ad_o), .ad_oe(u0_ad_oe),
      .ready(u0_ready), .sys_addr(u0_sys_addr), .sys_dat_o(u0_sys_dat_o),
      .sys_dat_i(sys_dat_i), .memr_n(u0_memr_n), .memw_n(u0_memw_n), .ior_n(u0_ior_n),
      .iow_n(u0_iow_n), .sys_rdy(sys_rdy), .bus_err(u0_bus_err)
   );

   // Instance u1: three memory wait states, for the abort-in-CMD case.
   pc_bus_ctrl #(.MEM_WS(3)) u1 (
      .clk(clk), .rst(rst), .a(a), .ad_i(ad_i), .ale(ale), .rd_n(rd_n), .wr_n(wr_n),
      .iom(iom), .den_n(den_n), .dtr(dtr), .ad_o(u1_ad_o), .ad_oe(u1_ad_oe),
      .ready(u1_ready), .sys_addr(u1_sys_addr), .sys_dat_o(u1_sys_dat_o),
      .sys_dat_i(sys_dat_i), .memr_n(u1_memr_n), .memw_n(u1_memw_n), .ior_n(u1_ior_n),
      .iow_n(u1_iow_n), .sys_rdy(sys_rdy), .bus_err(u1_bus_err)
   );

   logic        sel_b;
   logic [3:0]  m_stb;
   logic        m_ready, m_bus_err, m_ad_oe;
   logic [7:0]  m_ad_o, m_sys_dat_o;
   logic [19:0] m_sys_addr;

   // Strobe vector is {iow_n, ior_n, memw_n, memr_n}.
   assign m_stb       = sel_b ? {u1_iow_n, u1_ior_n, u1_memw_n, u1_memr_n}
                              : {u0_iow_n, u0_ior_n, u0_memw_n, u0_memr_n};
   assign m_ready     = sel_b ? u1_ready     : u0_ready;
   assign m_bus_err   = sel_b ? u1_bus_err   : u0_bus_err;
   assign m_ad_oe     = sel_b ? u1_ad_oe     : u0_ad_oe;
   assign m_ad_o      = sel_b ? u1_ad_o      : u0_ad_o;
   assign m_sys_dat_o = sel_b ? u1_sys_dat_o : u0_sys_dat_o;
   assign m_sys_addr  = sel_b ? u1_sys_addr  : u0_sys_addr;

   typedef struct {
      int          id;
      logic [3:0]  stb;
      logic [19:0] addr;
      logic [7:0]  wdat;
      int          low;
      int          rdy_low;
      logic        err;
      logic        rd_seen;
      logic [7:0]  rdat;
   } txn_t;

   txn_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", what, act, exp);
      end
   endtask

   function automatic txn_t mk(input int id, input logic [3:0] stb, input logic [19:0] addr,
                               input logic [7:0] wdat, input int low, input int rdy_low,
                               input logic err, input logic rd_seen, input logic [7:0] rdat);
      txn_t t;
      t.id = id; t.stb = stb; t.addr = addr; t.wdat = wdat; t.low = low;
      t.rdy_low = rdy_low; t.err = err; t.rd_seen = rd_seen; t.rdat = rdat;
      return t;
   endfunction

   task automatic compare(input txn_t e, input txn_t o);
      string p;
      p = $sformatf("txn%0d", e.id);
      check({p, ".strobe"},    32'(o.stb),     32'(e.stb));
      check({p, ".sys_addr"},  32'(o.addr),    32'(e.addr));
      check({p, ".sys_dat_o"}, 32'(o.wdat),    32'(e.wdat));
      check({p, ".low_clks"},  32'(o.low),     32'(e.low));
      check({p, ".rdy_low"},   32'(o.rdy_low), 32'(e.rdy_low));
      check({p, ".bus_err"},   32'(o.err),     32'(e.err));
      check({p, ".ad_oe"},     32'(o.rd_seen), 32'(e.rd_seen));
      if (e.rd_seen) check({p, ".ad_o"}, 32'(o.rdat), 32'(e.rdat));
   endtask

   // A transaction opens on the first strobe-low or bus_err sample and closes
   // on the first sample with every strobe high.
   initial begin : monitor
      txn_t cur;
      logic active;
      active = 1'b0;
      cur    = mk(0, 4'hF, '0, '0, 0, 0, 1'b0, 1'b0, '0);
      forever begin
         @(negedge clk);
         if (!active && ((m_stb != 4'hF) || m_bus_err)) begin
            active = 1'b1;
            cur    = mk(0, m_stb, m_sys_addr, m_sys_dat_o, 0, 0, 1'b0, 1'b0, '0);
         end
         if (active) begin
            if (m_stb != 4'hF) begin
               cur.low++;
               if (!m_ready) cur.rdy_low++;
            end
            if (m_bus_err) cur.err = 1'b1;
            if (m_ad_oe) begin
               cur.rd_seen = 1'b1;
               cur.rdat    = m_ad_o;
            end
            if (m_stb == 4'hF) begin
               active = 1'b0;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_txn: got strobe %0h with no expectation queued", cur.stb);
               end else begin
                  compare(exp_q.pop_front(), cur);
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m_ready && (m_stb != 4'hF)) && (n < 100));
      check("done_reached", 32'(n < 100), 32'd1);
   endtask

   task automatic start_addr(input logic io, input logic [19:0] addr);
      @(posedge clk); #1;
      ale = 1'b1; a = addr; iom = io;
      @(posedge clk); #1;
      ale = 1'b0; a = '0;
   endtask

   task automatic bus_cycle(input logic io, input logic wr, input logic [19:0] addr,
                            input logic [7:0] wdat, input int gap);
      start_addr(io, addr);
      repeat (gap) begin
         @(posedge clk); #1;
      end
      if (wr) begin
         wr_n = 1'b0; ad_i = wdat; dtr = 1'b1;
      end else begin
         rd_n = 1'b0; dtr = 1'b0;
      end
      den_n = 1'b0;
      wait_done();
      @(posedge clk); #1;
      rd_n = 1'b1; wr_n = 1'b1; den_n = 1'b1; dtr = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      rst = 1'b0; sel_b = 1'b0;
      a = '0; ad_i = '0; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; iom = 1'b0;
      den_n = 1'b1; dtr = 1'b0; sys_dat_i = '0; sys_rdy = 1'b1;

      // Reset values before any clock edge.
      #3;
      check("rst.strobes",   32'(m_stb),       32'hF);
      check("rst.u1_strobes", 32'({u1_iow_n, u1_ior_n, u1_memw_n, u1_memr_n}), 32'hF);
      check("rst.ready",     32'(m_ready),     32'd1);
      check("rst.ad_oe",     32'(m_ad_oe),     32'd0);
      check("rst.bus_err",   32'(m_bus_err),   32'd0);
      check("rst.sys_addr",  32'(m_sys_addr),  32'd0);
      check("rst.sys_dat_o", 32'(m_sys_dat_o), 32'd0);
      check("rst.ad_o",      32'(m_ad_o),      32'd0);
      #10;
      rst = 1'b1;

      // Zero-wait memory read with one idle ADDR clock: strobe low in CMD,
      // WAIT, DONE and the extra DONE clock before the CPU releases rd_n.
      sys_rdy = 1'b1; sys_dat_i = 8'hEA;
      exp_q.push_back(mk(1, 4'b1110, 20'hFFFF0, 8'h00, 4, 2, 1'b0, 1'b1, 8'hEA));
      bus_cycle(1'b0, 1'b0, 20'hFFFF0, 8'h00, 1);

      // One-wait I/O write: CMD lasts IO_WS+1 = 2 clocks, then one WAIT clock.
      do_reset();
      exp_q.push_back(mk(2, 4'b0111, 20'h00060, 8'h55, 5, 3, 1'b0, 1'b0, 8'h00));
      bus_cycle(1'b1, 1'b1, 20'h00060, 8'h55, 0);

      // sys_rdy stuck low: four WAIT clocks, then error pulse and 8'hFF.
      do_reset();
      sys_rdy = 1'b0;
      exp_q.push_back(mk(3, 4'b1110, 20'h80000, 8'h00, 7, 5, 1'b1, 1'b1, 8'hFF));
      bus_cycle(1'b0, 1'b0, 20'h80000, 8'h00, 0);

      // rd_n and wr_n both low in ADDR.
      do_reset();
      exp_q.push_back(mk(4, 4'hF, 20'hABCDE, 8'h00, 0, 0, 1'b1, 1'b0, 8'h00));
      start_addr(1'b0, 20'hABCDE);
      rd_n = 1'b0; wr_n = 1'b0;
      @(posedge clk); #1;
      check("both_low.bus_err", 32'(m_bus_err), 32'd1);
      check("both_low.strobes", 32'(m_stb),     32'hF);
      check("both_low.ready",   32'(m_ready),   32'd1);
      @(posedge clk); #1;
      check("both_low.err_pulse_end", 32'(m_bus_err), 32'd0);
      rd_n = 1'b1; wr_n = 1'b1;

      // Reset asserted in WAIT.
      do_reset();
      sys_rdy = 1'b0;
      exp_q.push_back(mk(5, 4'b1110, 20'h01234, 8'h00, 2, 2, 1'b0, 1'b0, 8'h00));
      start_addr(1'b0, 20'h01234);
      rd_n = 1'b0; den_n = 1'b0; dtr = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      #1;
      rst = 1'b0;
      #1;
      check("mid_rst.strobes", 32'(m_stb),   32'hF);
      check("mid_rst.ready",   32'(m_ready), 32'd1);
      check("mid_rst.ad_oe",   32'(m_ad_oe), 32'd0);
      rd_n = 1'b1; den_n = 1'b1;
      #10;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("post_rst.strobes",  32'(m_stb),      32'hF);
      check("post_rst.ready",    32'(m_ready),    32'd1);
      check("post_rst.sys_addr", 32'(m_sys_addr), 32'd0);

      // Three-wait memory read completes, then a second read is aborted in CMD.
      do_reset();
      sel_b = 1'b1; sys_rdy = 1'b1; sys_dat_i = 8'h3C;
      exp_q.push_back(mk(6, 4'b1110, 20'h12345, 8'h00, 7, 5, 1'b0, 1'b1, 8'h3C));
      bus_cycle(1'b0, 1'b0, 20'h12345, 8'h00, 0);
      sys_dat_i = 8'hC3;
      exp_q.push_back(mk(7, 4'b1110, 20'h2AAAA, 8'h00, 2, 2, 1'b0, 1'b0, 8'h00));
      start_addr(1'b0, 20'h2AAAA);
      rd_n = 1'b0; den_n = 1'b0; dtr = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rd_n = 1'b1; den_n = 1'b1;
      @(posedge clk); #1;
      check("abort.memr_n", 32'(m_stb),   32'hF);
      check("abort.ready",  32'(m_ready), 32'd1);
      check("abort.ad_o",   32'(m_ad_o),  32'h3C);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
